// File: rtl/lab1_imul_mul_arbiter.sv
// Round-robin front end sharing one variable-latency multiplier between two requesters.
// Optional LAB1_IMUL_MUL_ARB_PERF_EN adds per-requester response counters and a line-trace field.
module lab1_imul_mul_arbiter #(
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32,
    parameter int p_cnt_nbits  = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_req_nbits-1:0]  req0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_req_nbits-1:0]  req1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,

    output logic                    mul_req_val,
    input  logic                    mul_req_rdy,
    output logic [p_req_nbits-1:0]  mul_req_msg,
    input  logic                    mul_resp_val,
    output logic                    mul_resp_rdy,
    input  logic [p_resp_nbits-1:0] mul_resp_msg
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
    ,
    output logic [p_cnt_nbits-1:0]  cnt0,
    output logic [p_cnt_nbits-1:0]  cnt1,
    output logic [15:0]             line_trace
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   owner;
    logic                   prio;
    logic [p_req_nbits-1:0] msg_reg;

    logic                   grant;
    logic                   req_fire;
    logic                   resp_fire;

    // NOTE: non-blocking assignments on every flop so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= 1'b0;
            prio    <= 1'b0;
            msg_reg <= '0;
        end else if (req_fire) begin
            owner   <= grant;
            prio    <= ~grant;
            msg_reg <= grant ? req1_msg : req0_msg;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_next   = state;
        grant        = (req0_val && req1_val) ? prio : req1_val;
        req_fire     = 1'b0;
        resp_fire    = 1'b0;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        resp0_val    = 1'b0;
        resp0_msg    = '0;
        resp1_val    = 1'b0;
        resp1_msg    = '0;
        mul_req_val  = 1'b0;
        mul_req_msg  = '0;
        mul_resp_rdy = 1'b0;

        // Outputs are forced quiet while reset is held, even though the flops already read IDLE.
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    req0_rdy = (req0_val || req1_val) && !grant;
                    req1_rdy = (req0_val || req1_val) &&  grant;
                    req_fire = (req0_val && req0_rdy) || (req1_val && req1_rdy);
                    if (req_fire) state_next = ST_ISSUE;
                end
                ST_ISSUE: begin
                    mul_req_val = 1'b1;
                    mul_req_msg = msg_reg;
                    if (mul_req_rdy) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    mul_resp_rdy = owner ? resp1_rdy : resp0_rdy;
                    if (owner) begin
                        resp1_val = mul_resp_val;
                        resp1_msg = mul_resp_msg;
                    end else begin
                        resp0_val = mul_resp_val;
                        resp0_msg = mul_resp_msg;
                    end
                    resp_fire = mul_resp_val && mul_resp_rdy;
                    if (resp_fire) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (resp_fire) begin
            if (owner && !(&cnt1))       cnt1 <= cnt1 + 1'b1;
            else if (!owner && !(&cnt0)) cnt0 <= cnt0 + 1'b1;
        end
    end

    // Two ASCII characters: state letter (I/S/W) followed by owner digit.
    always_comb begin
        line_trace[7:0] = 8'h30 | {7'd0, owner};
        case (state)
            ST_ISSUE: line_trace[15:8] = 8'h53;
            ST_WAIT:  line_trace[15:8] = 8'h57;
            default:  line_trace[15:8] = 8'h49;
        endcase
    end
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = (p_cnt_nbits > 0);
`endif

endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// Directed bench for lab1_imul_mul_arbiter; the bench plays the multiplier by hand.
// Define LAB1_IMUL_MUL_ARB_PERF_EN to also cover the counters and line trace.
module tb_lab1_imul_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic        req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic [63:0] req0_msg, req1_msg, mul_req_msg;
    logic [31:0] resp0_msg, resp1_msg, mul_resp_msg;
    logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
    logic [15:0] cnt0, cnt1, line_trace;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    lab1_imul_mul_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg)
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
        ,
        .cnt0         (cnt0),
        .cnt1         (cnt1),
        .line_trace   (line_trace)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ops(input logic [31:0] a, input logic [31:0] b);
        return {a, b};
    endfunction

    // One full transaction starting in IDLE with the requests already driven; multiplier is ready.
    task automatic serve(input string tag, input logic own, input logic [63:0] exp_msg,
                         input logic [31:0] prod, input logic keep, input logic [63:0] nxt);
        check({tag, "_rdy0"}, 64'(req0_rdy), 64'(!own));
        check({tag, "_rdy1"}, 64'(req1_rdy), 64'(own));
        tick();
        if (own) begin req1_val = keep; req1_msg = nxt; end
        else     begin req0_val = keep; req0_msg = nxt; end
        #1;
        check({tag, "_mreqval"}, 64'(mul_req_val), 64'd1);
        check({tag, "_mreqmsg"}, mul_req_msg, exp_msg);
        check({tag, "_busyrdy"}, 64'({req0_rdy, req1_rdy}), 64'd0);
        tick();
        mul_resp_val = 1'b1;
        mul_resp_msg = prod;
        #1;
        check({tag, "_mreqoff"}, 64'(mul_req_val), 64'd0);
        check({tag, "_respval"}, 64'(own ? resp1_val : resp0_val), 64'd1);
        check({tag, "_respmsg"}, 64'(own ? resp1_msg : resp0_msg), 64'(prod));
        check({tag, "_otherval"}, 64'(own ? resp0_val : resp1_val), 64'd0);
        check({tag, "_mresprdy"}, 64'(mul_resp_rdy), 64'd1);
        tick();
        mul_resp_val = 1'b0;
        mul_resp_msg = '0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req0_val = 1'b1; req0_msg = '0; resp0_rdy = 1'b1;
        req1_val = 1'b0; req1_msg = '0; resp1_rdy = 1'b1;
        mul_req_rdy = 1'b1; mul_resp_val = 1'b0; mul_resp_msg = '0;
        #3;
        check("rst_req0rdy", 64'(req0_rdy), 64'd0);
        check("rst_mreqval", 64'(mul_req_val), 64'd0);
        check("rst_mresprdy", 64'(mul_resp_rdy), 64'd0);
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
        check("rst_cnt0", 64'(cnt0), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Simultaneous requests after reset: requester 0 first, then 1.
        req0_val = 1'b1; req0_msg = ops(32'd2, 32'd7);
        req1_val = 1'b1; req1_msg = ops(32'd4, 32'd4);
        #1;
        serve("t2a", 1'b0, ops(32'd2, 32'd7), 32'd14, 1'b0, '0);
        serve("t2b", 1'b1, ops(32'd4, 32'd4), 32'd16, 1'b0, '0);

        // Both continuously valid: grants alternate, starting with 0 again.
        req0_val = 1'b1; req0_msg = ops(32'd3, 32'd4);
        req1_val = 1'b1; req1_msg = ops(32'd10, 32'd11);
        #1;
        serve("t3_0", 1'b0, ops(32'd3, 32'd4),     32'd12,    1'b1, ops(32'd5, 32'd6));
        serve("t3_1", 1'b1, ops(32'd10, 32'd11),   32'd110,   1'b1, ops(32'd12, 32'd13));
        serve("t3_2", 1'b0, ops(32'd5, 32'd6),     32'd30,    1'b1, ops(32'd7, 32'd8));
        serve("t3_3", 1'b1, ops(32'd12, 32'd13),   32'd156,   1'b1, ops(32'd100, 32'd200));
        serve("t3_4", 1'b0, ops(32'd7, 32'd8),     32'd56,    1'b0, '0);
        serve("t3_5", 1'b1, ops(32'd100, 32'd200), 32'd20000, 1'b0, '0);

        // Single requester 0.
        req0_val = 1'b1; req0_msg = ops(32'd3, 32'd5);
        #1;
        serve("t1", 1'b0, 64'h0000_0003_0000_0005, 32'd15, 1'b0, '0);

        // Multiplier stalls the request: prio is now 1, so requester 1 wins.
        req0_val = 1'b1; req0_msg = ops(32'd2, 32'd3);
        req1_val = 1'b1; req1_msg = ops(32'd6, 32'd7);
        mul_req_rdy = 1'b0;
        #1;
        check("t4_rdy1", 64'(req1_rdy), 64'd1);
        check("t4_rdy0", 64'(req0_rdy), 64'd0);
        tick();
        req1_val = 1'b0;
        #1;
        check("t4_mreqval", 64'(mul_req_val), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stallmsg", mul_req_msg, ops(32'd6, 32'd7));
            check("t4_stallrdy", 64'({req0_rdy, req1_rdy}), 64'd0);
        end
        mul_req_rdy = 1'b1;
        tick();
        mul_resp_val = 1'b1; mul_resp_msg = 32'd42;
        #1;
        check("t4_resp1msg", 64'(resp1_msg), 64'd42);
        check("t4_resp0val", 64'(resp0_val), 64'd0);
        tick();
        mul_resp_val = 1'b0;
        #1;
        check("t4_idle_rdy0", 64'(req0_rdy), 64'd1);
        req0_val = 1'b0;

        // Response backpressure from requester 1 while requester 0 waits.
        req1_val = 1'b1; req1_msg = ops(32'd9, 32'd9);
        #1;
        check("t5_rdy1", 64'(req1_rdy), 64'd1);
        tick();
        req1_val = 1'b0;
        req0_val = 1'b1; req0_msg = ops(32'd2, 32'd2);
        #1;
        check("t5_mreqmsg", mul_req_msg, ops(32'd9, 32'd9));
        tick();
        resp1_rdy = 1'b0; mul_resp_val = 1'b1; mul_resp_msg = 32'd81;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t5_mresprdy", 64'(mul_resp_rdy), 64'd0);
            check("t5_resp1val", 64'(resp1_val), 64'd1);
            check("t5_resp1msg", 64'(resp1_msg), 64'd81);
            check("t5_req0rdy", 64'(req0_rdy), 64'd0);
            tick();
        end
        resp1_rdy = 1'b1;
        #1;
        check("t5_fire_rdy", 64'(mul_resp_rdy), 64'd1);
        tick();
        mul_resp_val = 1'b0;
        #1;
        check("t5_idle_rdy0", 64'(req0_rdy), 64'd1);

        // Reset while waiting on requester 0's response.
        tick();
        req0_val = 1'b0;
        tick();
        resp0_rdy = 1'b0; mul_resp_val = 1'b1; mul_resp_msg = 32'd4;
        #1;
        check("t6_resp0val", 64'(resp0_val), 64'd1);
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
        check("t6_cnt0", 64'(cnt0), 64'd5);
        check("t6_cnt1", 64'(cnt1), 64'd6);
        check("t6_trace", 64'(line_trace), 64'h5730);
`endif
        reset = 1'b0;
        #1;
        check("t6_rst_resp0val", 64'(resp0_val), 64'd0);
        check("t6_rst_resp0msg", 64'(resp0_msg), 64'd0);
        check("t6_rst_mresprdy", 64'(mul_resp_rdy), 64'd0);
        req0_val = 1'b1; req1_val = 1'b1;
        #1;
        check("t6_rst_reqrdy", 64'({req0_rdy, req1_rdy}), 64'd0);
        tick();
        check("t6_rst_mreqval", 64'(mul_req_val), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_post_rdy0", 64'(req0_rdy), 64'd1);
        check("t6_post_rdy1", 64'(req1_rdy), 64'd0);
        check("t6_post_resp0val", 64'(resp0_val), 64'd0);
        check("t6_post_mresprdy", 64'(mul_resp_rdy), 64'd0);
`ifdef LAB1_IMUL_MUL_ARB_PERF_EN
        check("t6_post_cnt0", 64'(cnt0), 64'd0);
        check("t6_post_cnt1", 64'(cnt1), 64'd0);
        check("t6_post_trace", 64'(line_trace), 64'h4930);
`endif
        req0_val = 1'b0; req1_val = 1'b0; mul_resp_val = 1'b0; resp0_rdy = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
